adder_operand_ctrl: RTL and testbench

Operand-sequencing and result-capture stage wrapped around the 16-bit lab4 adders. It synchronizes the active-low LoadB and Run pushbuttons and latches B from SW on a LoadB press. On a Run press it latches A from SW, waits a fixed settle interval while the combinational adder resolves, then registers {CO, Sum} as a 17-bit result with a Done flag. It feeds operand registers A and B to the adder and consumes its Sum and CO outputs.

---
 rtl/adder_operand_ctrl.sv | 145 ++++++++++++++
 tb/tb_adder_operand_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_ctrl.sv
// adder_operand_ctrl
//
// Sits around the 16-bit lab4 adder. It feeds operands A and B to the
// adder and registers the adder's {CO, Sum} once it has settled.
//
//   LoadB falling press : B <= SW
//   Run falling press   : A <= SW, wait SETTLE_CYCLES, then Result <= {CO, Sum}
//                         and Done is raised
//
// Ports
//   Clk     in   system clock (50 MHz)
//   Reset   in   asynchronous reset, active low
//   LoadB   in   raw pushbutton, active low, asynchronous to Clk
//   Run     in   raw pushbutton, active low, asynchronous to Clk
//   SW      in   [15:0] operand switches
//   Sum     in   [15:0] adder sum
//   CO      in   adder carry-out
//   A       out  [15:0] registered operand A
//   B       out  [15:0] registered operand B
//   Result  out  [16:0] registered {CO, Sum}
//   Busy    out  high while an add is settling
//   Done    out  high while Result holds a valid capture
//
// SETTLE_CYCLES must be in the range 1..255.

module adder_operand_ctrl #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LoadB,
    input  logic        Run,
    input  logic [15:0] SW,
    input  logic [15:0] Sum,
    input  logic        CO,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [16:0] Result,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] COUNT_START = 8'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  count_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [16:0] result_q;
    logic        busy_q;
    logic        done_q;

    // Bit 0 is s1, bit 1 is s2, bit 2 is the history flop s3.
    logic [2:0]  loadBSync_q;
    logic [2:0]  runSync_q;

    logic        loadBFall;
    logic        runFall;
    logic        runReleased;

    // Two-flop synchronizers plus a history flop for each button. Every
    // flop resets to the released level (1) so that coming out of reset
    // with the buttons up cannot look like a press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            loadBSync_q <= 3'b111;
            runSync_q   <= 3'b111;
        end else begin
            loadBSync_q <= {loadBSync_q[1:0], LoadB};
            runSync_q   <= {runSync_q[1:0], Run};
        end
    end

    // A press is a one-cycle pulse on the synchronized high-to-low edge,
    // so a held button only ever produces one event.
    assign loadBFall   = loadBSync_q[2] & ~loadBSync_q[1];
    assign runFall     = runSync_q[2] & ~runSync_q[1];
    assign runReleased = runSync_q[1];

    // Sequencing FSM. All outputs are registered here so there is no
    // combinational path from any input to any output.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            count_q  <= 8'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            result_q <= 17'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Both presses in one cycle load A and B from the
                    // same switch value before the add starts.
                    if (loadBFall) begin
                        b_q <= SW;
                    end
                    if (runFall) begin
                        a_q     <= SW;
                        count_q <= COUNT_START;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Operands stay frozen and presses are dropped while
                    // the adder resolves.
                    if (count_q == 8'd0) begin
                        result_q <= {CO, Sum};
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= HOLD;
                    end else begin
                        count_q <= count_q - 8'd1;
                    end
                end
                HOLD: begin
                    // Run must be released before another add can begin.
                    if (runReleased) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign Result = result_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_adder_operand_ctrl.sv
// tb_adder_operand_ctrl
//
// Directed bench for adder_operand_ctrl. A behavioural 16-bit adder is
// wired between A/B and Sum/CO. Inputs change on the falling clock edge
// and outputs are sampled on the falling edge.

module tb_adder_operand_ctrl;

    localparam int SETTLE = 8;

    logic        clock;
    logic        reset;
    logic        loadB;
    logic        run;
    logic [15:0] sw;
    logic [15:0] sum;
    logic        co;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] result;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    adder_operand_ctrl #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .Clk   (clock),
        .Reset (reset),
        .LoadB (loadB),
        .Run   (run),
        .SW    (sw),
        .Sum   (sum),
        .CO    (co),
        .A     (a),
        .B     (b),
        .Result(result),
        .Busy  (busy),
        .Done  (done)
    );

    // Stand-in for the lab4 adder.
    assign {co, sum} = {1'b0, a} + {1'b0, b};

    // 50 MHz clock.
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [16:0] observed,
                               input logic [16:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic loadBLevel, input logic runLevel,
                                 input logic [15:0] swValue);
        loadB = loadBLevel;
        run   = runLevel;
        sw    = swValue;
    endtask

    // Press LoadB for three cycles, release, and let B settle.
    task automatic loadOperandB(input logic [15:0] swValue);
        applyStimulus(1'b0, 1'b1, swValue);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, swValue);
        waitCycles(3);
    endtask

    // Press Run for three cycles, release, and stop on the first falling
    // edge at which Result should be valid (SETTLE+3 edges after press).
    task automatic runAdd(input logic [15:0] swValue);
        applyStimulus(1'b1, 1'b0, swValue);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, swValue);
        waitCycles(SETTLE);
    endtask

    initial begin
        int busyRises;
        int doneRises;
        logic prevBusy;
        logic prevDone;

        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'h0000);
        waitCycles(3);

        $display("[TB] reset state");
        checkOutput("reset_A", {1'b0, a}, 17'h00000);
        checkOutput("reset_B", {1'b0, b}, 17'h00000);
        checkOutput("reset_Result", result, 17'h00000);
        checkOutput("reset_Busy", {16'd0, busy}, 17'd0);
        checkOutput("reset_Done", {16'd0, done}, 17'd0);

        reset = 1'b1;
        waitCycles(3);
        checkOutput("post_reset_Busy", {16'd0, busy}, 17'd0);

        $display("[TB] 0xfffe + 0x0001 with exact timing");
        loadOperandB(16'hfffe);
        checkOutput("t1_B", {1'b0, b}, 17'h0fffe);
        applyStimulus(1'b1, 1'b0, 16'h0001);
        waitCycles(2);
        checkOutput("t1_busy_before_k2", {16'd0, busy}, 17'd0);
        waitCycles(1);
        checkOutput("t1_busy_at_k2", {16'd0, busy}, 17'd1);
        checkOutput("t1_A", {1'b0, a}, 17'h00001);
        applyStimulus(1'b1, 1'b1, 16'h0001);
        waitCycles(SETTLE - 1);
        checkOutput("t1_done_early", {16'd0, done}, 17'd0);
        checkOutput("t1_busy_late", {16'd0, busy}, 17'd1);
        waitCycles(1);
        checkOutput("t1_Result", result, 17'h0ffff);
        checkOutput("t1_Done", {16'd0, done}, 17'd1);
        checkOutput("t1_busy_drop", {16'd0, busy}, 17'd0);

        $display("[TB] 0x0ece + 0x0385");
        loadOperandB(16'h0ece);
        runAdd(16'h0385);
        checkOutput("t2_Result", result, 17'h01253);
        checkOutput("t2_CO", {16'd0, result[16]}, 17'd0);

        $display("[TB] 0xffff + 0xffff");
        loadOperandB(16'hffff);
        runAdd(16'hffff);
        checkOutput("t3_Result", result, 17'h1fffe);
        checkOutput("t3_CO", {16'd0, result[16]}, 17'd1);

        $display("[TB] Run held for 50 cycles");
        waitCycles(2);
        busyRises = 0;
        doneRises = 0;
        prevBusy  = busy;
        prevDone  = done;
        applyStimulus(1'b1, 1'b0, 16'h0005);
        for (int i = 0; i < 50; i++) begin
            waitCycles(1);
            if (busy && !prevBusy) busyRises++;
            if (done && !prevDone) doneRises++;
            prevBusy = busy;
            prevDone = done;
        end
        checkOutput("hold_busy_pulses", 17'(busyRises), 17'd1);
        checkOutput("hold_captures", 17'(doneRises), 17'd1);
        checkOutput("hold_Done", {16'd0, done}, 17'd1);
        checkOutput("hold_Result", result, 17'h10004);
        applyStimulus(1'b1, 1'b1, 16'h0005);
        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            if (busy && !prevBusy) busyRises++;
            prevBusy = busy;
        end
        checkOutput("release_no_pulse", 17'(busyRises), 17'd1);
        checkOutput("release_Done", {16'd0, done}, 17'd1);
        applyStimulus(1'b1, 1'b0, 16'h0006);
        waitCycles(3);
        checkOutput("repress_busy", {16'd0, busy}, 17'd1);
        checkOutput("repress_Done_cleared", {16'd0, done}, 17'd0);
        applyStimulus(1'b1, 1'b1, 16'h0006);
        waitCycles(SETTLE);
        checkOutput("repress_Result", result, 17'h10005);

        $display("[TB] LoadB during SETTLE");
        waitCycles(2);
        loadOperandB(16'h0010);
        applyStimulus(1'b1, 1'b0, 16'h0020);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h0020);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 16'h1234);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h1234);
        checkOutput("settle_B_held", {1'b0, b}, 17'h00010);
        checkOutput("settle_A_held", {1'b0, a}, 17'h00020);
        waitCycles(SETTLE);
        checkOutput("settle_Result", result, 17'h00030);
        checkOutput("settle_B_after", {1'b0, b}, 17'h00010);

        $display("[TB] reset during SETTLE");
        runAdd(16'h0040);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 16'h0100);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h0100);
        waitCycles(2);
        checkOutput("midreset_busy_before", {16'd0, busy}, 17'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("midreset_A", {1'b0, a}, 17'h00000);
        checkOutput("midreset_B", {1'b0, b}, 17'h00000);
        checkOutput("midreset_Result", result, 17'h00000);
        checkOutput("midreset_Busy", {16'd0, busy}, 17'd0);
        checkOutput("midreset_Done", {16'd0, done}, 17'd0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(SETTLE + 6);
        checkOutput("postreset_Done", {16'd0, done}, 17'd0);
        checkOutput("postreset_Result", result, 17'h00000);
        checkOutput("postreset_Busy", {16'd0, busy}, 17'd0);

        $display("[TB] LoadB and Run together");
        applyStimulus(1'b0, 1'b0, 16'h0003);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h0003);
        waitCycles(SETTLE);
        checkOutput("both_A", {1'b0, a}, 17'h00003);
        checkOutput("both_B", {1'b0, b}, 17'h00003);
        checkOutput("both_Result", result, 17'h00006);
        checkOutput("both_Done", {16'd0, done}, 17'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
